// File: rtl/reg_scan_pkg.sv
// Shared types and constants for the register scan dumper.
// FSM state encoding, register-index / data widths and the FIFO entry layout.
package reg_scan_pkg;

    localparam int REG_IDX_W = 5;
    localparam int DATA_W    = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } scan_state_t;

    typedef struct packed {
        logic [REG_IDX_W-1:0] idx;
        logic [DATA_W-1:0]    data;
    } fifo_entry_t;

endpackage

// File: rtl/scan_fifo.sv
// Small synchronous FIFO buffering captured {idx,data} words.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
// The head word reads as zero while the FIFO is empty.
module scan_fifo
    import reg_scan_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        srst,
    input  logic        i_push,
    input  fifo_entry_t i_data,
    input  logic        i_pop,
    output fifo_entry_t o_head,
    output logic        o_full,
    output logic        o_empty
);

    localparam int AW = $clog2(DEPTH);

    fifo_entry_t    r_mem [DEPTH];
    logic [AW:0]    r_wr_ptr;
    logic [AW:0]    r_rd_ptr;
    logic           w_do_push;
    logic           w_do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    // Storage write; contents need no reset because the head is gated when empty.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

    // Read/write pointer update.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_scan_dumper.sv
// Register scan dumper: walks register indices first_reg..last_reg (wrapping
// modulo 32), reads each through the regNo/val port and streams {idx,data}
// words through a small FIFO with valid/ready handshake.
// Optional build macro REG_SCAN_SKIP_ZERO_EN: index 0 is stepped over without
// being pushed (the scan still terminates when cur reaches the end index).
module reg_scan_dumper
    import reg_scan_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 startin,
    input  logic                 trig,
    input  logic [REG_IDX_W-1:0] first_reg,
    input  logic [REG_IDX_W-1:0] last_reg,
    output logic [REG_IDX_W-1:0] regNo,
    input  logic [DATA_W-1:0]    val,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_data,
    output logic [REG_IDX_W-1:0] out_idx,
    output logic                 busy,
    output logic                 done
);

    scan_state_t          r_state;
    logic [REG_IDX_W-1:0] r_cur;
    logic [REG_IDX_W-1:0] r_end_idx;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_pop;
    logic                 w_space;
    logic                 w_skip;
    logic                 w_in_scan;
    logic                 w_advance;
    logic                 w_push;
    fifo_entry_t          w_entry;
    fifo_entry_t          w_head;

`ifdef REG_SCAN_SKIP_ZERO_EN
    assign w_skip = (r_cur == '0);
`else
    assign w_skip = 1'b0;
`endif

    // A slot is free if the FIFO has room or its head leaves this cycle.
    assign w_pop     = out_ready && !w_empty;
    assign w_space   = !w_full || w_pop;
    assign w_in_scan = (r_state == SCAN);
    // A skipped index costs one cycle but never waits for FIFO space.
    assign w_advance = w_in_scan && (w_skip || w_space);
    assign w_push    = w_in_scan && !w_skip && w_space;
    assign w_entry   = {r_cur, val};

    assign regNo     = w_in_scan ? r_cur : '0;
    assign out_valid = !w_empty;
    assign out_idx   = w_head.idx;
    assign out_data  = w_head.data;
    assign busy      = r_busy;
    assign done      = r_done;

    scan_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .srst    (startin),
        .i_push  (w_push),
        .i_data  (w_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Scan control FSM with registered busy/done.
    always_ff @(posedge clk) begin
        if (startin) begin
            r_state   <= IDLE;
            r_cur     <= '0;
            r_end_idx <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (trig) begin
                        r_cur     <= first_reg;
                        r_end_idx <= last_reg;
                        r_busy    <= 1'b1;
                        r_state   <= SCAN;
                    end
                end
                SCAN: begin
                    if (w_advance) begin
                        r_cur <= r_cur + 1'b1;
                        if (r_cur == r_end_idx) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_empty) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_scan_dumper.sv
// Bench for reg_scan_dumper: a register-file image drives val, an expected
// word queue is built from each accepted scan's index range, and a monitor
// checks every handshake, head stability under backpressure and done pulses.
module tb_reg_scan_dumper;

    localparam int FIFO_DEPTH = 4;
`ifdef REG_SCAN_SKIP_ZERO_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic        clk;
    logic        startin;
    logic        trig;
    logic [4:0]  first_reg;
    logic [4:0]  last_reg;
    logic [4:0]  regNo;
    logic [31:0] val;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_idx;
    logic        busy;
    logic        done;

    logic [31:0] rf [32];
    assign val = rf[regNo];

    reg_scan_dumper #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk       (clk),
        .startin   (startin),
        .trig      (trig),
        .first_reg (first_reg),
        .last_reg  (last_reg),
        .regNo     (regNo),
        .val       (val),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    int          done_cnt = 0;
    logic [36:0] exp_q [$];
    int          hs_idx_q [$];
    logic [31:0] hs_data_q [$];
    int          hs_cyc_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: word-by-word comparison against the expected queue.
    logic        prev_v = 1'b0, prev_r = 1'b0, prev_rst = 1'b1;
    logic [36:0] prev_word = '0;
    always @(negedge clk) begin
        if (!startin) begin
            if (prev_v && !prev_r && !prev_rst) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_word", 64'({out_idx, out_data}), 64'(prev_word));
            end
            if (out_valid && out_ready) begin
                hs_idx_q.push_back(int'(out_idx));
                hs_data_q.push_back(out_data);
                hs_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_word: got idx %0d data %h, expected none", out_idx, out_data);
                end else begin
                    check("word", 64'({out_idx, out_data}), 64'(exp_q.pop_front()));
                end
            end
            if (done) begin
                done_cnt++;
                check("done_drained", 64'(exp_q.size()), 64'd0);
            end
        end
        prev_v    = out_valid;
        prev_r    = out_ready;
        prev_rst  = startin;
        prev_word = {out_idx, out_data};
    end

    // Model: the words a scan f..l must produce, in order.
    task automatic push_expected(input int f, input int l);
        int i = f;
        for (int k = 0; k < 32; k++) begin
            if (!(SKIP && i == 0)) exp_q.push_back({5'(i), rf[i]});
            if (i == l) break;
            i = (i + 1) % 32;
        end
    endtask

    task automatic start_scan(input int f, input int l);
        push_expected(f, l);
        first_reg = 5'(f);
        last_reg  = 5'(l);
        trig      = 1'b1;
        @(posedge clk); #1;
        trig = 1'b0;
        check("busy_after_trig", 64'(busy), 64'd1);
    endtask

    task automatic finish_scan(input int pct, input int target);
        int k;
        for (k = 0; k < 3000; k++) begin
            if (done_cnt >= target) break;
            out_ready = ($urandom_range(99) < pct);
            @(posedge clk); #1;
        end
        if (k == 3000) begin
            n_vec++;
            n_err++;
            $display("FAIL done_timeout: got %0d pulses expected %0d", done_cnt, target);
        end
        check("done_count", 64'(done_cnt), 64'(target));
        check("model_empty", 64'(exp_q.size()), 64'd0);
        check("busy_after_done", 64'(busy), 64'd0);
    endtask

    task automatic clear_hs();
        hs_idx_q.delete();
        hs_data_q.delete();
        hs_cyc_q.delete();
    endtask

    initial begin
        int d;
        int wrap_exp [$];
        int tb_exp [$];
        startin = 1'b1; trig = 1'b0; first_reg = '0; last_reg = '0; out_ready = 1'b0;
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        repeat (3) @(posedge clk); #1;
        check("rst_regNo", 64'(regNo), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_idx", 64'(out_idx), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        startin = 1'b0;
        @(posedge clk); #1;

        // Full-speed scan 8..11.
        rf[8] = 32'h0800_0008; rf[11] = 32'h1100_0011;
        clear_hs(); out_ready = 1'b1;
        start_scan(8, 11);
        finish_scan(100, 1);
        check("fs_count", 64'(hs_idx_q.size()), 64'd4);
        if (hs_idx_q.size() == 4) begin
            check("fs_first_idx", 64'(hs_idx_q[0]), 64'd8);
            check("fs_first_data", 64'(hs_data_q[0]), 64'h0800_0008);
            check("fs_last_idx", 64'(hs_idx_q[3]), 64'd11);
            check("fs_last_data", 64'(hs_data_q[3]), 64'h1100_0011);
            check("fs_consecutive", 64'(hs_cyc_q[3] - hs_cyc_q[0]), 64'd3);
        end

        // Wrap-around 30..1.
        clear_hs();
        start_scan(30, 1);
        finish_scan(100, 2);
`ifdef REG_SCAN_SKIP_ZERO_EN
        wrap_exp = '{30, 31, 1};
`else
        wrap_exp = '{30, 31, 0, 1};
`endif
        check("wrap_count", 64'(hs_idx_q.size()), 64'(wrap_exp.size()));
        if (hs_idx_q.size() == wrap_exp.size())
            foreach (wrap_exp[i]) check("wrap_idx", 64'(hs_idx_q[i]), 64'(wrap_exp[i]));

        // Backpressure: full 0..31 scan with the consumer stalled.
        clear_hs(); out_ready = 1'b0;
        start_scan(0, 31);
        repeat (15) @(posedge clk); #1;
        check("bp_regNo_frozen", 64'(regNo), SKIP ? 64'd5 : 64'd4);
        check("bp_valid", 64'(out_valid), 64'd1);
        check("bp_head_idx", 64'(out_idx), SKIP ? 64'd1 : 64'd0);
        check("bp_busy", 64'(busy), 64'd1);
        finish_scan(60, 3);
        check("bp_count", 64'(hs_idx_q.size()), SKIP ? 64'd31 : 64'd32);

        // Single register 9.
        rf[9] = 32'h0000_0005;
        clear_hs(); out_ready = 1'b1;
        start_scan(9, 9);
        finish_scan(100, 4);
        check("single_count", 64'(hs_idx_q.size()), 64'd1);
        if (hs_idx_q.size() == 1) begin
            check("single_idx", 64'(hs_idx_q[0]), 64'd9);
            check("single_data", 64'(hs_data_q[0]), 64'd5);
        end

        // Mid-scan reset.
        out_ready = 1'b0;
        start_scan(0, 31);
        repeat (3) @(posedge clk); #1;
        startin = 1'b1;
        @(posedge clk); #1;
        startin = 1'b0;
        exp_q.delete();
        check("mrst_valid", 64'(out_valid), 64'd0);
        check("mrst_busy", 64'(busy), 64'd0);
        check("mrst_regNo", 64'(regNo), 64'd0);
        out_ready = 1'b1;
        repeat (40) @(posedge clk); #1;
        check("mrst_no_done", 64'(done_cnt), 64'd4);
        start_scan(5, 7);
        finish_scan(100, 5);

        // Trig while busy is ignored.
        clear_hs(); out_ready = 1'b1;
        start_scan(0, 3);
        first_reg = 5'd20; last_reg = 5'd25; trig = 1'b1;
        @(posedge clk); #1;
        trig = 1'b0;
        finish_scan(100, 6);
        repeat (10) @(posedge clk); #1;
        check("tb_single_done", 64'(done_cnt), 64'd6);
        tb_exp = SKIP ? '{1, 2, 3} : '{0, 1, 2, 3};
        check("tb_count", 64'(hs_idx_q.size()), 64'(tb_exp.size()));
        if (hs_idx_q.size() == tb_exp.size())
            foreach (tb_exp[i]) check("tb_idx", 64'(hs_idx_q[i]), 64'(tb_exp[i]));

        // Randomised scans.
        d = 6;
        for (int t = 0; t < 25; t++) begin
            int f = $urandom_range(31);
            int l = $urandom_range(31);
            int pct = $urandom_range(100, 15);
            for (int i = 0; i < 32; i++) rf[i] = $urandom;
            out_ready = ($urandom_range(1) == 1);
            start_scan(f, l);
            d++;
            finish_scan(pct, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
